// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, column patterns and decode helpers for the keypad operand entry
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_REL} scan_state_t;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  localparam int DIGITS = 4;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  function automatic logic [3:0] next_col(input logic [3:0] col);
    case (col)
      COL0:    next_col = COL1;
      COL1:    next_col = COL2;
      COL2:    next_col = COL3;
      default: next_col = COL0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      COL1:    col_index = 2'd1;
      COL2:    col_index = 2'd2;
      COL3:    col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

  // Lowest-index active-low row wins when several rows are down.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    if (!rows[0])      row_index = 2'd0;
    else if (!rows[1]) row_index = 2'd1;
    else if (!rows[2]) row_index = 2'd2;
    else               row_index = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row synchronizer, column rotation and press/release debounce FSM
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] KEY_R,
  output logic [3:0] KEY_C,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    r_meta;
  logic [3:0]    rs;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  scan_state_t   state;
  logic          pressed;
  logic [3:0]    cur_code;

  assign pressed  = (rs != 4'b1111);
  assign cur_code = {row_index(rs), col_index(KEY_C)};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_meta    <= 4'b1111;
      rs        <= 4'b1111;
      KEY_C     <= COL0;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      state     <= SCAN;
      key_event <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      r_meta    <= KEY_R;
      rs        <= r_meta;
      key_event <= 1'b0;
      case (state)
        SCAN: begin
          if (pressed) begin
            key_code <= cur_code;
            if (DEBOUNCE_CNT <= 1) begin
              key_event <= 1'b1;
              db_cnt    <= '0;
              state     <= HELD;
            end else begin
              db_cnt <= DW'(1);
              state  <= DB_PRESS;
            end
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            KEY_C    <= next_col(KEY_C);
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DB_PRESS: begin
          if (pressed && cur_code == key_code) begin
            if (db_cnt == DB_LAST) begin
              key_event <= 1'b1;
              db_cnt    <= '0;
              state     <= HELD;
            end else begin
              db_cnt <= db_cnt + DW'(1);
            end
          end else begin
            // scan_cnt is kept, so rotation picks up from the frozen column
            db_cnt <= '0;
            state  <= SCAN;
          end
        end
        HELD: begin
          if (!pressed) begin
            if (DEBOUNCE_CNT <= 1) begin
              db_cnt <= '0;
              state  <= SCAN;
            end else begin
              db_cnt <= DW'(1);
              state  <= DB_REL;
            end
          end
        end
        default: begin
          if (pressed) begin
            db_cnt <= '0;
            state  <= HELD;
          end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            state  <= SCAN;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// rtl/keypad_operand_entry.sv - four-digit X/Y operand accumulator with valid/ready handoff; KEYPAD_PRESS_COUNT_EN adds press_times/last_code
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] KEY_R,
  output logic [3:0] KEY_C,
  output logic [7:0] X,
  output logic [7:0] Y,
  output logic       operands_valid,
  input  logic       operands_ready
`ifdef KEYPAD_PRESS_COUNT_EN
  ,
  output logic [2:0] press_times,
  output logic [3:0] last_code
`endif
);

  logic             key_event;
  logic [3:0]       key_code;
  logic [CNT_W-1:0] cnt;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_scanner (
    .clk      (clk),
    .clr      (clr),
    .KEY_R    (KEY_R),
    .KEY_C    (KEY_C),
    .key_event(key_event),
    .key_code (key_code)
  );

  // While valid is up the pair is frozen; digits arriving then are dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      X              <= 8'h00;
      Y              <= 8'h00;
      operands_valid <= 1'b0;
      cnt            <= '0;
    end else if (operands_valid) begin
      if (operands_ready) begin
        operands_valid <= 1'b0;
        cnt            <= '0;
      end
    end else if (key_event) begin
      if (cnt == '0) {X, Y} <= {12'h000, key_code};
      else           {X, Y} <= {X[3:0], Y, key_code};
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST_DIGIT) operands_valid <= 1'b1;
    end
  end

`ifdef KEYPAD_PRESS_COUNT_EN
  assign press_times = cnt;

  always_ff @(posedge clk) begin
    if (clr)            last_code <= 4'h0;
    else if (key_event) last_code <= key_code;
  end
`endif

endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb/tb_keypad_operand_entry.sv - scoreboard bench: keypad model drives rows, monitor checks every X/Y/valid update
module tb_keypad_operand_entry;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        operands_ready = 1'b0;
  logic [3:0]  KEY_R;
  logic [3:0]  KEY_C;
  logic [7:0]  X;
  logic [7:0]  Y;
  logic        operands_valid;
  logic [15:0] keys = 16'h0000;
`ifdef KEYPAD_PRESS_COUNT_EN
  logic [2:0]  press_times;
  logic [3:0]  last_code;
`endif

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  keypad_operand_entry #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .KEY_R         (KEY_R),
    .KEY_C         (KEY_C),
    .X             (X),
    .Y             (Y),
    .operands_valid(operands_valid),
    .operands_ready(operands_ready)
`ifdef KEYPAD_PRESS_COUNT_EN
    ,
    .press_times   (press_times),
    .last_code     (last_code)
`endif
  );

  always #5 clk = ~clk;

  // Key 4*r+c pulls row r low only while its column c is driven low.
  always_comb begin
    KEY_R = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && KEY_C[c] === 1'b0) KEY_R[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge on which the given column becomes driven.
  task automatic align(input int col);
    logic [3:0] pat;
    logic [3:0] prev;
    bit found;
    pat   = 4'b1111 ^ (4'b0001 << col);
    prev  = KEY_C;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(posedge clk);
      #1;
      if (KEY_C == pat && prev != pat) found = 1;
      prev = KEY_C;
    end
    if (!found) chk("align_timeout", 32'(KEY_C), 32'(pat));
  endtask

  task automatic press(input int code);
    align(code % 4);
    keys[code] = 1'b1;
    tick(30);
    keys[code] = 1'b0;
    tick(30);
  endtask

  initial begin
    fork
      begin : monitor
        logic [16:0] prev_o;
        logic [16:0] cur_o;
        logic [16:0] e;
        prev_o = '0;
        forever begin
          @(negedge clk);
          cur_o = {operands_valid, X, Y};
          if (clr) begin
            prev_o = cur_o;
          end else if (cur_o !== prev_o) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_update: got %h expected no change from %h", cur_o, prev_o);
            end else begin
              e = exp_q.pop_front();
              chk("scoreboard", 32'(cur_o), 32'(e));
            end
            prev_o = cur_o;
          end
        end
      end
    join_none

    clr = 1'b1;
    tick(3);
    chk("reset_key_c", 32'(KEY_C), 32'h0000000e);
    chk("reset_x", 32'(X), 32'h0);
    chk("reset_y", 32'(Y), 32'h0);
    chk("reset_valid", 32'(operands_valid), 32'h0);
    clr = 1'b0;
    tick(2);

    // clr mid-DB_PRESS on a column-2 key
    align(2);
    keys[2] = 1'b1;
    tick(4);
    clr     = 1'b1;
    keys[2] = 1'b0;
    tick(1);
    chk("midpress_reset_key_c", 32'(KEY_C), 32'h0000000e);
    chk("midpress_reset_x", 32'(X), 32'h0);
    chk("midpress_reset_y", 32'(Y), 32'h0);
    chk("midpress_reset_valid", 32'(operands_valid), 32'h0);
    clr = 1'b0;
    tick(40);

    // Clean entry of 1,2,3,4
    exp_q.push_back({1'b0, 8'h00, 8'h01});
    press(1);
    exp_q.push_back({1'b0, 8'h00, 8'h12});
    press(2);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("press_times_2", 32'(press_times), 32'd2);
`endif
    exp_q.push_back({1'b0, 8'h01, 8'h23});
    press(3);
    exp_q.push_back({1'b1, 8'h12, 8'h34});
    press(4);
    chk("entry_valid", 32'(operands_valid), 32'h1);
    chk("entry_x", 32'(X), 32'h12);
    chk("entry_y", 32'(Y), 32'h34);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("press_times_4", 32'(press_times), 32'd4);
    chk("last_code_4", 32'(last_code), 32'h4);
`endif

    // Key while valid and ready low is dropped
    press(9);
    chk("held_valid", 32'(operands_valid), 32'h1);
    chk("held_x", 32'(X), 32'h12);
    chk("held_y", 32'(Y), 32'h34);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("dropped_last_code", 32'(last_code), 32'h9);
    chk("dropped_press_times", 32'(press_times), 32'd4);
`endif
    exp_q.push_back({1'b0, 8'h12, 8'h34});
    operands_ready = 1'b1;
    tick(1);
    chk("handshake_valid_drop", 32'(operands_valid), 32'h0);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("handshake_press_times", 32'(press_times), 32'd0);
`endif
    // ready left high with valid low has no effect
    exp_q.push_back({1'b0, 8'h00, 8'h09});
    press(9);
    operands_ready = 1'b0;
    chk("restart_y", 32'(Y), 32'h09);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("restart_press_times", 32'(press_times), 32'd1);
`endif

    // Bounce: low 2, high 1, low 5 gives one digit
    exp_q.push_back({1'b0, 8'h00, 8'h90});
    align(0);
    keys[0] = 1'b1;
    tick(2);
    keys[0] = 1'b0;
    tick(1);
    keys[0] = 1'b1;
    tick(5);
    keys[0] = 1'b0;
    tick(30);
    // Two-cycle press is rejected
    align(1);
    keys[1] = 1'b1;
    tick(2);
    keys[1] = 1'b0;
    tick(30);
    chk("bounce_y", 32'(Y), 32'h90);

    // Rows 1 and 3 in column 2, plus a column-0 key while held
    exp_q.push_back({1'b0, 8'h09, 8'h06});
    align(2);
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    tick(8);
    keys[0] = 1'b1;
    tick(25);
    keys[6]  = 1'b0;
    keys[14] = 1'b0;
    keys[0]  = 1'b0;
    tick(30);
    chk("multikey_y", 32'(Y), 32'h06);
`ifdef KEYPAD_PRESS_COUNT_EN
    chk("multikey_last_code", 32'(last_code), 32'h6);
`endif

    exp_q.push_back({1'b1, 8'h90, 8'h65});
    press(5);
    chk("second_pair_valid", 32'(operands_valid), 32'h1);
    exp_q.push_back({1'b0, 8'h90, 8'h65});
    operands_ready = 1'b1;
    tick(2);
    operands_ready = 1'b0;
    tick(10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
